// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, FSM state enum and decode helper shared by the core.
package mips_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        return op == OP_RTYPE ? (fn == FN_ADD || fn == FN_SUB || fn == FN_AND || fn == FN_OR || fn == FN_SLT)
                              : (op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J);
    endfunction
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x XLEN register file, two async read ports, one sync write port, reg0 reads zero.
module mips_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);
    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n)
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        else if (we && wa != 5'd0)
            regs[wa] <= wd;

    assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
    assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB) on a req/ready memory port.
// Define MIPS_ILLEGAL_HALT_EN to halt on illegal instructions; otherwise they execute as NOPs.
module mips_multicycle_core import mips_pkg::*; #(
    parameter int XLEN = 32,
    parameter int AW = 8,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            clr_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            halted,
    output logic [AW-1:0]   pc_out
);
    state_t state, state_nx;
    logic [AW-1:0] pc, pc_j;
    logic [31:0] ir;
    logic [XLEN-1:0] a, b, imm, res, rd1, rd2, op2, alu;
    logic [5:0] op, fn;
    logic [4:0] wa;

    assign op = ir[31:26];
    assign fn = ir[5:0];
    assign wa = op == OP_RTYPE ? ir[15:11] : ir[20:16];

`ifdef MIPS_ILLEGAL_HALT_EN
    localparam state_t ILL_NX = S_HALT;
    assign halted = state == S_HALT;
`else
    localparam state_t ILL_NX = S_FETCH;
    assign halted = 1'b0;
`endif

    // Jump keeps the PC bits above the 28-bit target field, if the PC has any.
    if (AW > 28) begin : g_jhi
        assign pc_j = {pc[AW-1:28], ir[25:0], 2'b00};
    end else begin : g_jlo
        assign pc_j = AW'({ir[25:0], 2'b00});
    end

    mips_regfile #(.XLEN(XLEN)) u_rf (
        .clk  (clk),
        .clr_n(clr_n),
        .ra1  (ir[25:21]),
        .ra2  (ir[20:16]),
        .rd1  (rd1),
        .rd2  (rd2),
        .we   (state == S_WB),
        .wa   (wa),
        .wd   (res)
    );

    always_comb begin
        op2 = op == OP_RTYPE ? b : imm;
        alu = op != OP_RTYPE ? a + op2 :
              fn == FN_SUB   ? a - op2 :
              fn == FN_AND   ? a & op2 :
              fn == FN_OR    ? a | op2 :
              fn == FN_SLT   ? XLEN'($signed(a) < $signed(op2)) : a + op2;
    end

    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) state <= S_FETCH;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_nx = is_legal(op, fn) ? S_EXEC : ILL_NX;
            S_EXEC:   state_nx = (op == OP_LW || op == OP_SW) ? S_MEM :
                                 (op == OP_BEQ || op == OP_J) ? S_FETCH : S_WB;
            S_MEM:    state_nx = !mem_ready ? S_MEM : op == OP_LW ? S_WB : S_FETCH;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = state;
        endcase
    end

    // res carries the ALU result / memory address, then the load data for WB.
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            pc  <= RESET_PC;
            ir  <= '0;
            a   <= '0;
            b   <= '0;
            imm <= '0;
            res <= '0;
        end else begin
            case (state)
                S_FETCH:
                    if (mem_ready) begin
                        ir <= mem_rdata[31:0];
                        pc <= pc + AW'(4);
                    end
                S_DECODE: begin
                    a   <= rd1;
                    b   <= rd2;
                    imm <= {{(XLEN-16){ir[15]}}, ir[15:0]};
                end
                S_EXEC: begin
                    res <= alu;
                    if (op == OP_BEQ && a == b) pc <= pc + (AW'(imm) << 2);
                    if (op == OP_J) pc <= pc_j;
                end
                S_MEM:
                    if (mem_ready && op == OP_LW) res <= mem_rdata;
                default: ;
            endcase
        end

    assign mem_req   = clr_n && (state == S_FETCH || state == S_MEM);
    assign mem_we    = state == S_MEM && op == OP_SW;
    assign mem_addr  = {state == S_MEM ? res[AW-1:2] : pc[AW-1:2], 2'b00};
    assign mem_wdata = b;
    assign pc_out    = pc;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed programs against a bench memory with programmable ready latency.
module tb_mips_multicycle_core;
    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic mem_req, mem_we, mem_ready, halted;
    logic [7:0] mem_addr, pc_out;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] prog [64];
    logic [31:0] dmem [64];
    logic [63:0] dvalid;
    int lat = 0, wcnt = 0, nwr = 0, w0 = 0, waits = 0;
    bit hold = 1'b0, found = 1'b0;
    int total = 0, passes = 0;

    always #5 clk = ~clk;

    mips_multicycle_core #(.XLEN(32), .AW(8), .RESET_PC(8'h00)) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .halted   (halted),
        .pc_out   (pc_out)
    );

    assign mem_ready = mem_req && !hold && wcnt >= lat;
    assign mem_rdata = dvalid[mem_addr[7:2]] ? dmem[mem_addr[7:2]] : prog[mem_addr[7:2]];

    always @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            dvalid <= '0;
            wcnt <= 0;
        end else if (mem_req && mem_ready) begin
            wcnt <= 0;
            if (mem_we) begin
                dmem[mem_addr[7:2]] <= mem_wdata;
                dvalid[mem_addr[7:2]] <= 1'b1;
                nwr <= nwr + 1;
            end
        end else
            wcnt <= mem_req ? wcnt + 1 : 0;

    function automatic logic [31:0] r_(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction
    function automatic logic [31:0] i_(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] j_(input logic [7:0] addr);
        return {6'h02, 20'h0, addr[7:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk);
        clr_n = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic wait_write(input string tag, input logic [7:0] addr, input logic [31:0] data, input int bound);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            found = mem_req && mem_ready && mem_we;
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        chk({tag, "_data"}, mem_wdata, data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // addi/addi/add then store $3 so the sum is visible on the bus
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0] = i_(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1] = i_(6'h08, 5'd0, 5'd2, 16'd7);
        prog[2] = r_(5'd1, 5'd2, 5'd3, 6'h20);
        prog[3] = i_(6'h2B, 5'd0, 5'd3, 16'h0040);
        prog[4] = j_(8'h10);
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'h00);
        chk("rst_halted", 32'(halted), 32'd0);
        release_rst();
        #1;
        chk("rel_mem_req", 32'(mem_req), 32'd1);
        chk("rel_mem_we", 32'(mem_we), 32'd0);
        chk("rel_mem_addr", 32'(mem_addr), 32'h00);
        ticks(12);
        chk("add_pc_12cyc", 32'(pc_out), 32'h0C);
        wait_write("add_sum", 8'h40, 32'd12, 20);

        // sw/lw with three wait cycles per access
        restart();
        prog[0] = i_(6'h08, 5'd0, 5'd3, 16'd12);
        prog[1] = i_(6'h2B, 5'd0, 5'd3, 16'h0010);
        prog[2] = i_(6'h23, 5'd0, 5'd4, 16'h0010);
        prog[3] = i_(6'h2B, 5'd0, 5'd4, 16'h0044);
        lat = 3;
        release_rst();
        for (int i = 0; i < 80 && !(mem_req && mem_we); i++) @(negedge clk);
        waits = 0;
        for (int i = 0; i < 10 && !mem_ready; i++) begin
            chk("sw_wait_addr", 32'(mem_addr), 32'h10);
            chk("sw_wait_data", mem_wdata, 32'd12);
            chk("sw_wait_we", 32'(mem_we), 32'd1);
            waits++;
            @(negedge clk);
        end
        chk("sw_wait_cycles", 32'(waits), 32'd3);
        chk("sw_xfer_addr", 32'(mem_addr), 32'h10);
        chk("sw_xfer_data", mem_wdata, 32'd12);
        wait_write("lw_value", 8'h44, 32'd12, 80);
        lat = 0;

        // beq taken back to itself every three cycles
        restart();
        prog[0] = i_(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1] = i_(6'h08, 5'd0, 5'd2, 16'd2);
        prog[2] = j_(8'h20);
        prog[8] = i_(6'h04, 5'd1, 5'd1, 16'hFFFF);
        release_rst();
        ticks(11);
        chk("beq_t_pc11", 32'(pc_out), 32'h20);
        ticks(1);
        chk("beq_t_pc12", 32'(pc_out), 32'h24);
        ticks(2);
        chk("beq_t_pc14", 32'(pc_out), 32'h20);
        ticks(1);
        chk("beq_t_pc15", 32'(pc_out), 32'h24);
        ticks(2);
        chk("beq_t_pc17", 32'(pc_out), 32'h20);

        // beq not taken falls through
        restart();
        prog[0] = i_(6'h08, 5'd0, 5'd1, 16'd1);
        prog[1] = i_(6'h08, 5'd0, 5'd2, 16'd2);
        prog[2] = j_(8'h20);
        prog[8] = i_(6'h04, 5'd1, 5'd2, 16'd5);
        prog[9] = j_(8'h24);
        release_rst();
        ticks(14);
        chk("beq_nt_pc", 32'(pc_out), 32'h24);
        chk("beq_nt_fetch", 32'(mem_addr), 32'h24);
        ticks(1);
        chk("j_fetch_pc", 32'(pc_out), 32'h28);
        ticks(2);
        chk("j_self_pc", 32'(pc_out), 32'h24);

        // $0 write discard and ALU ops with a negative operand
        restart();
        prog[0]  = i_(6'h08, 5'd0, 5'd0, 16'd9);
        prog[1]  = i_(6'h2B, 5'd0, 5'd0, 16'h0040);
        prog[2]  = i_(6'h08, 5'd0, 5'd6, 16'hFFFF);
        prog[3]  = i_(6'h08, 5'd0, 5'd7, 16'd1);
        prog[4]  = r_(5'd6, 5'd7, 5'd5, 6'h2A);
        prog[5]  = i_(6'h2B, 5'd0, 5'd5, 16'h0044);
        prog[6]  = r_(5'd7, 5'd6, 5'd8, 6'h22);
        prog[7]  = r_(5'd6, 5'd7, 5'd9, 6'h24);
        prog[8]  = r_(5'd7, 5'd8, 5'd10, 6'h25);
        prog[9]  = r_(5'd7, 5'd6, 5'd11, 6'h2A);
        prog[10] = i_(6'h2B, 5'd0, 5'd8, 16'h0048);
        prog[11] = i_(6'h2B, 5'd0, 5'd9, 16'h004C);
        prog[12] = i_(6'h2B, 5'd0, 5'd10, 16'h0050);
        prog[13] = i_(6'h2B, 5'd0, 5'd11, 16'h0054);
        prog[14] = j_(8'h38);
        release_rst();
        wait_write("r0_zero", 8'h40, 32'd0, 30);
        wait_write("slt_neg", 8'h44, 32'd1, 40);
        wait_write("sub", 8'h48, 32'd2, 40);
        wait_write("and", 8'h4C, 32'd1, 20);
        wait_write("or", 8'h50, 32'd3, 20);
        wait_write("slt_pos", 8'h54, 32'd0, 20);

        // illegal opcode 0x3F, then unsupported funct 0x26
        restart();
        prog[0] = i_(6'h08, 5'd0, 5'd1, 16'd3);
        prog[1] = 32'hFC00_0000;
        prog[2] = r_(5'd1, 5'd1, 5'd1, 6'h26);
        prog[3] = i_(6'h2B, 5'd0, 5'd1, 16'h0040);
        prog[4] = j_(8'h10);
        release_rst();
        ticks(6);
`ifdef MIPS_ILLEGAL_HALT_EN
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_req", 32'(mem_req), 32'd0);
        ticks(10);
        chk("ill_halted_hold", 32'(halted), 32'd1);
        chk("ill_req_hold", 32'(mem_req), 32'd0);
`else
        chk("ill_nop_pc", 32'(pc_out), 32'h08);
        chk("ill_nop_fetch", 32'(mem_addr), 32'h08);
        chk("ill_halted", 32'(halted), 32'd0);
        wait_write("ill_funct_nop", 8'h40, 32'd3, 20);
`endif

        // reset while a store is stalled in MEM
        restart();
        prog[0] = i_(6'h08, 5'd3, 5'd3, 16'd12);
        prog[1] = i_(6'h2B, 5'd0, 5'd3, 16'h0040);
        release_rst();
        ticks(6);
        hold = 1'b1;
        ticks(1);
        chk("stall_we", 32'(mem_we), 32'd1);
        chk("stall_addr", 32'(mem_addr), 32'h40);
        ticks(2);
        chk("stall_req", 32'(mem_req), 32'd1);
        w0 = nwr;
        #2;
        clr_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_pc", 32'(pc_out), 32'h00);
        @(negedge clk);
        clr_n = 1'b1;
        hold = 1'b0;
        #1;
        chk("mid_rst_nowrite", 32'(nwr), 32'(w0));
        chk("mid_rst_refetch", 32'(mem_addr), 32'h00);
        chk("mid_rst_refetch_req", 32'(mem_req), 32'd1);
        wait_write("mid_rst_regs_cleared", 8'h40, 32'd12, 20);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath and register width (legal 32 only when instruction fetch is used; data ops truncate/extend to XLEN).
REQ-002 Parameter AW, default 8, SHALL set the byte-address width of PC and mem_addr.
REQ-003 Parameter RESET_PC, default 0, SHALL set the PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 clr_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mem_req  output  1  memory access request, held until accepted.
REQ-007 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 mem_addr  output  AW  byte address, word-aligned (bits [1:0]=0).
REQ-009 mem_wdata  output  XLEN  store data.
REQ-010 mem_rdata  input  XLEN  read data, valid in cycle mem_ready=1.
REQ-011 mem_ready  input  1  access complete; transfer occurs when mem_req&mem_ready.
REQ-012 halted  output  1  core stopped (illegal opcode, see Configuration).
REQ-013 pc_out  output  AW  current PC for debug.

Function
REQ-014 Core SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready SHALL latch IR and PC<=PC+4 (wraps modulo 2^AW), go DECODE; else stay.
REQ-016 DECODE: SHALL read rs/rt into A/B latches and sign-extend imm[15:0] to XLEN; go EXEC.
REQ-017 Supported ops: R-type add, sub, and, or, slt (funct 0x20,0x22,0x24,0x25,0x2A); addi (0x08); lw (0x23); sw (0x2B); beq (0x04); j (0x02).
REQ-018 EXEC: R-type/addi SHALL compute result (add/sub wrap, no overflow trap; slt signed) and go WB; lw/sw SHALL compute A+imm as address and go MEM; beq SHALL set PC<=PC+(imm<<2) if A==B and go FETCH; j SHALL set PC<={PC[AW-1:28 or top],target<<2 truncated to AW} and go FETCH.
REQ-019 MEM: mem_req=1, mem_we=(sw), mem_addr=address[AW-1:0] with [1:0] forced 0, mem_wdata=B; on mem_ready lw latches mem_rdata and goes WB, sw goes FETCH.
REQ-020 WB: SHALL write result to rd (R-type) or rt (addi, lw); write to register 0 SHALL be discarded; go FETCH.
REQ-021 Register 0 SHALL always read 0.
REQ-022 mem_req SHALL be 0 in DECODE, EXEC, WB, HALT; address/we/wdata SHALL be stable while mem_req=1 and mem_ready=0.
REQ-023 Latency with mem_ready tied 1: R-type/addi 4 cycles, lw 5, sw 4, beq/j 3.
REQ-024 Unsupported R-type funct SHALL be treated per illegal-opcode rule.

Reset
REQ-025 clr_n=0 SHALL immediately force state FETCH, PC=RESET_PC, IR=0, halted=0, mem_req=0 (mem_req asserts from first cycle after release), all registers 0.
REQ-026 Reset mid-access SHALL abandon the access; no register or PC update from that instruction.

Configuration
REQ-027 With macro MIPS_ILLEGAL_HALT_EN defined, an illegal opcode/funct in DECODE SHALL enter HALT, assert halted=1, and stay until reset.
REQ-028 Without MIPS_ILLEGAL_HALT_EN, illegal instructions SHALL execute as NOP (DECODE->FETCH) and halted SHALL be tied 0.

Structure
REQ-029 Opcode/funct constants and the FSM state enum SHALL live in shared package mips_pkg.
REQ-030 Register file SHALL be sub-module mips_regfile (2 async read ports, 1 sync write port, 32 x XLEN, reg0 zero).

Verification
REQ-031 Reset, program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 with mem_ready=1 -> $3=12 after 12 cycles, pc_out=0x0C.
REQ-032 sw $3,0x10($0) then lw $4,0x10($0) with mem_ready delayed 3 cycles per access -> write at addr 0x10 data 12; $4=12; mem_addr/wdata stable during wait.
REQ-033 beq $1,$1,-1 at PC 0x20 -> PC returns to 0x20 every 3 cycles; beq $1,$2 not taken -> PC 0x24.
REQ-034 addi $0,$0,9 -> $0 still reads 0; slt $5,$6,$7 with $6=-1,$7=1 -> $5=1.
REQ-035 Opcode 0x3F with MIPS_ILLEGAL_HALT_EN -> halted=1, mem_req=0 forever; without -> next instruction fetched at PC+4.
REQ-036 clr_n pulsed low during MEM of sw with mem_ready=0 -> no write observed, PC=RESET_PC, fetch restarts.
